// File: rtl/serial_rx.sv
// serial_rx: asynchronous UART receiver, DATA_BITS data bits, optional odd/even parity, 1 or 2 stop bits.
// Latency: oe rises one cycle after the last stop-bit decision (the decision is one cycle later with SERIAL_RX_MAJORITY_EN).
// Backpressure: none; oe is a single-cycle strobe and data/flags hold until the next oe.
module serial_rx #(
  parameter int unsigned CLK_FREQUENCY_HZ = 108_000_000,
  parameter int unsigned SERIAL_BPS       = 3_000_000,
  parameter int unsigned DATA_BITS        = 8,
  parameter int unsigned PARITY           = 0,
  parameter int unsigned STOP_BITS        = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] data,
  output logic                 oe,
  output logic                 frame_error,
  output logic                 parity_error,
  output logic                 break_detect
);

  localparam int unsigned DIVISOR = CLK_FREQUENCY_HZ / SERIAL_BPS;
  localparam int unsigned CW      = $clog2(DIVISOR);
`ifdef SERIAL_RX_MAJORITY_EN
  // Vote over centre-1, centre, centre+1; the decision lands on centre+1.
  localparam int unsigned SAMP_OFS = DIVISOR / 2 + 1;
`else
  localparam int unsigned SAMP_OFS = DIVISOR / 2;
`endif
  localparam logic [CW-1:0] SAMP_PT   = CW'(SAMP_OFS);
  localparam logic [CW-1:0] CNT_LAST  = CW'(DIVISOR - 1);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);
  localparam logic [3:0]    DATA_LAST = 4'(DATA_BITS - 1);
  localparam logic [1:0]    STOP_LAST = 2'(STOP_BITS - 1);
  localparam bit            HAS_PAR   = (PARITY != 0);
  localparam bit            PAR_ODD   = (PARITY == 1);

  // Illegal configurations stop elaboration.
  generate
    if (DIVISOR < 8) begin : g_bad_divisor
      $error("serial_rx: CLK_FREQUENCY_HZ / SERIAL_BPS must be at least 8");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
      $error("serial_rx: DATA_BITS must be 5..9");
    end
    if (PARITY > 2) begin : g_bad_parity
      $error("serial_rx: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("serial_rx: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_WAIT_IDLE
  } state_t;

  state_t                 r_state;
  state_t                 w_next;
  logic                   r_sync1, r_sync2, r_rx_prev;
  logic [CW-1:0]          r_cnt;
  logic [3:0]             r_idx;
  logic [DATA_BITS-1:0]   r_shift;
  logic                   r_par;
  logic                   r_stop0;
  logic                   r_ferr;
  logic [DATA_BITS-1:0]   r_data;
  logic                   r_oe, r_fe, r_pe, r_brk;

  logic                   w_rx_s, w_fall, w_samp_en, w_bit;
  logic                   w_clr, w_done;
  logic                   w_par_exp, w_pe, w_stop0, w_brk;

  // Two-flop synchroniser plus one history flop for start-edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_rx_prev <= 1'b1;
    end else begin
      r_sync1   <= rx;
      r_sync2   <= r_sync1;
      r_rx_prev <= r_sync2;
    end
  end

  assign w_rx_s    = r_sync2;
  assign w_fall    = ~w_rx_s & r_rx_prev;
  assign w_samp_en = (r_cnt == SAMP_PT);

`ifdef SERIAL_RX_MAJORITY_EN
  logic r_rx_prev2;

  // Second history flop provides the centre-1 sample for the vote.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_rx_prev2 <= 1'b1;
    else       r_rx_prev2 <= r_rx_prev;
  end

  assign w_bit = (r_rx_prev2 & r_rx_prev) | (r_rx_prev2 & w_rx_s) | (r_rx_prev & w_rx_s);
`else
  assign w_bit = w_rx_s;
`endif

  // Frame checks evaluated at the final stop decision.
  assign w_par_exp = PAR_ODD ? ~(^r_shift) : (^r_shift);
  assign w_pe      = HAS_PAR & (r_par ^ w_par_exp);
  assign w_stop0   = (r_idx == 4'd0) ? w_bit : r_stop0;
  assign w_brk     = (r_shift == '0) & ~(HAS_PAR & r_par) & ~w_stop0;

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Next-state logic; w_clr starts a new frame, w_done marks the final stop decision.
  always_comb begin
    w_next = r_state;
    w_clr  = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_fall) begin
          w_next = S_START;
          w_clr  = 1'b1;
        end
      end
      S_START: begin
        if (w_samp_en) w_next = w_bit ? S_IDLE : S_DATA;
      end
      S_DATA: begin
        if (w_samp_en && r_idx == DATA_LAST) w_next = HAS_PAR ? S_PARITY : S_STOP;
      end
      S_PARITY: begin
        if (w_samp_en) w_next = S_STOP;
      end
      S_STOP: begin
        if (w_samp_en && r_idx[1:0] == STOP_LAST) begin
          w_done = 1'b1;
          if (!w_bit) begin
            w_next = S_WAIT_IDLE;
          end else if (w_fall) begin
            // With voting the decision cycle can already hold the next start edge.
            w_next = S_START;
            w_clr  = 1'b1;
          end else begin
            w_next = S_IDLE;
          end
        end
      end
      S_WAIT_IDLE: begin
        if (w_rx_s) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Bit timing, sample capture and output registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
      r_par   <= 1'b0;
      r_stop0 <= 1'b1;
      r_ferr  <= 1'b0;
      r_data  <= '0;
      r_oe    <= 1'b0;
      r_fe    <= 1'b0;
      r_pe    <= 1'b0;
      r_brk   <= 1'b0;
    end else begin
      r_oe <= w_done;

      if (r_state == S_DATA && w_samp_en) r_shift <= {w_bit, r_shift[DATA_BITS-1:1]};
      if (r_state == S_PARITY && w_samp_en) r_par <= w_bit;
      if (r_state == S_STOP && w_samp_en) begin
        if (r_idx == 4'd0) r_stop0 <= w_bit;
        if (!w_bit)        r_ferr  <= 1'b1;
      end

      if (w_clr) begin
        r_cnt  <= CNT_ONE;
        r_ferr <= 1'b0;
      end else if (r_state != S_IDLE && r_state != S_WAIT_IDLE) begin
        r_cnt <= (r_cnt == CNT_LAST) ? '0 : r_cnt + CNT_ONE;
      end

      if (w_clr || w_next != r_state) r_idx <= '0;
      else if (w_samp_en)             r_idx <= r_idx + 4'd1;

      if (w_done) begin
        r_data <= r_shift;
        r_fe   <= r_ferr | ~w_bit;
        r_pe   <= w_pe;
        r_brk  <= w_brk;
      end
    end
  end

  assign data         = r_data;
  assign oe           = r_oe;
  assign frame_error  = r_fe;
  assign parity_error = r_pe;
  assign break_detect = r_brk;

endmodule

// File: tb/tb_serial_rx.sv
// tb_serial_rx: drives three receiver builds (8N1, 8E1, 7N2) with directed and random frames.
// Expected words, flags and oe cycle come from decoding the driven waveform at the bit centres.
// Each line is idle high whenever it is not carrying a frame.
module tb_serial_rx;

  localparam int D = 108_000_000 / 3_000_000;
`ifdef SERIAL_RX_MAJORITY_EN
  localparam int MAJ = 1;
`else
  localparam int MAJ = 0;
`endif

  typedef struct {
    int         inst;
    logic [8:0] d;
    logic       fe;
    logic       pe;
    logic       brk;
    int         cyc;
  } rec_t;

  logic       clk;
  logic       reset;
  logic       rx_a, rx_b, rx_c;
  logic [7:0] data_a, data_b;
  logic [6:0] data_c;
  logic       oe_a, oe_b, oe_c;
  logic       fe_a, fe_b, fe_c;
  logic       pe_a, pe_b, pe_c;
  logic       brk_a, brk_b, brk_c;

  int   cyc = 0;
  int   n_assert = 0;
  int   n_fail = 0;
  rec_t obs_q[$];
  rec_t exp_q[$];
  logic wave[$];

  serial_rx #(.CLK_FREQUENCY_HZ(108_000_000), .SERIAL_BPS(3_000_000), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_a (
    .clk(clk), .reset(reset), .rx(rx_a), .data(data_a), .oe(oe_a),
    .frame_error(fe_a), .parity_error(pe_a), .break_detect(brk_a));

  serial_rx #(.CLK_FREQUENCY_HZ(108_000_000), .SERIAL_BPS(3_000_000), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_b (
    .clk(clk), .reset(reset), .rx(rx_b), .data(data_b), .oe(oe_b),
    .frame_error(fe_b), .parity_error(pe_b), .break_detect(brk_b));

  serial_rx #(.CLK_FREQUENCY_HZ(108_000_000), .SERIAL_BPS(3_000_000), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) u_c (
    .clk(clk), .reset(reset), .rx(rx_c), .data(data_c), .oe(oe_c),
    .frame_error(fe_c), .parity_error(pe_c), .break_detect(brk_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Capture every oe strobe with the cycle it appeared in.
  always @(negedge clk) begin
    if (oe_a) obs_q.push_back('{0, {1'b0, data_a}, fe_a, pe_a, brk_a, cyc});
    if (oe_b) obs_q.push_back('{1, {1'b0, data_b}, fe_b, pe_b, brk_b, cyc});
    if (oe_c) obs_q.push_back('{2, {2'b00, data_c}, fe_c, pe_c, brk_c, cyc});
  end

  function automatic int cfg_db(input int i);
    return (i == 2) ? 7 : 8;
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1) ? 2 : 0;
  endfunction
  function automatic int cfg_sb(input int i);
    return (i == 2) ? 2 : 1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, expv);
    end
  endtask

  task automatic set_rx(input int inst, input logic v);
    case (inst)
      0:       rx_a = v;
      1:       rx_b = v;
      default: rx_c = v;
    endcase
  endtask

  // Hold the line at v for n clock periods, recording the waveform.
  task automatic drive(input int inst, input logic v, input int n);
    for (int i = 0; i < n; i++) begin
      set_rx(inst, v);
      wave.push_back(v);
      @(negedge clk);
    end
  endtask

  function automatic logic wv(input int i);
    if (i < 0 || i >= wave.size()) return 1'b1;
    return wave[i];
  endfunction

  // Line value the receiver should decide for bit k of the recorded frame.
  function automatic logic samp(input int k);
    int c;
    logic a, b, e;
    c = k * D + D / 2;
    a = wv(c - 1);
    b = wv(c);
    e = wv(c + 1);
    if (MAJ != 0) return (a & b) | (a & e) | (b & e);
    return b;
  endfunction

  // Decode the recorded waveform into the expected delivery, if any.
  task automatic model(input int inst, input int start);
    rec_t r;
    int   db, pb, sb;
    logic pbit, s, s0;
    db = cfg_db(inst);
    pb = (cfg_par(inst) != 0) ? 1 : 0;
    sb = cfg_sb(inst);
    if (samp(0)) return;
    r.inst = inst;
    r.d = '0;
    for (int i = 0; i < db; i++) r.d[i] = samp(1 + i);
    pbit = 1'b0;
    r.pe = 1'b0;
    if (pb != 0) begin
      pbit = samp(1 + db);
      r.pe = pbit ^ ((cfg_par(inst) == 1) ? ~(^r.d) : (^r.d));
    end
    r.fe = 1'b0;
    s0 = 1'b1;
    for (int j = 0; j < sb; j++) begin
      s = samp(1 + db + pb + j);
      if (!s) r.fe = 1'b1;
      if (j == 0) s0 = s;
    end
    r.brk = (r.d == 9'd0) && !pbit && !s0;
    r.cyc = start + 2 + (db + pb + sb) * D + D / 2 + 1 + MAJ;
    exp_q.push_back(r);
  endtask

  // Send one frame; stops[j] is stop bit j, glitch_bit gets a 1-cycle low at its centre.
  task automatic send_frame(input int inst, input logic [8:0] word, input logic par_flip,
                            input logic [1:0] stops, input int glitch_bit, input int last_len);
    int db, pb, sb, nb, len, start;
    logic [8:0] w;
    logic pbit, v;
    db = cfg_db(inst);
    pb = (cfg_par(inst) != 0) ? 1 : 0;
    sb = cfg_sb(inst);
    nb = 1 + db + pb + sb;
    w = word & 9'((1 << db) - 1);
    pbit = ((cfg_par(inst) == 1) ? ~(^w) : (^w)) ^ par_flip;
    wave.delete();
    start = cyc;
    for (int k = 0; k < nb; k++) begin
      if (k == 0)                       v = 1'b0;
      else if (k <= db)                 v = w[k-1];
      else if (pb != 0 && k == db + 1)  v = pbit;
      else                              v = stops[k-1-db-pb];
      len = (k == nb - 1) ? last_len : D;
      if (k == glitch_bit) begin
        drive(inst, v, D / 2);
        drive(inst, 1'b0, 1);
        drive(inst, v, len - D / 2 - 1);
      end else begin
        drive(inst, v, len);
      end
    end
    model(inst, start);
  endtask

  // Hold the line low for n cycles starting from idle.
  task automatic line_low(input int inst, input int n);
    int start;
    wave.delete();
    start = cyc;
    drive(inst, 1'b0, n);
    model(inst, start);
  endtask

  // Wait for all expected deliveries (bounded), then compare against the observations.
  task automatic check_all(input string tag);
    int lim;
    rec_t o, e;
    lim = cyc + 3000;
    while (obs_q.size() < exp_q.size() && cyc < lim) @(negedge clk);
    repeat (50) @(negedge clk);
    chk({tag, ".oe_count"}, obs_q.size(), exp_q.size());
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      chk({tag, ".inst"}, o.inst, e.inst);
      chk({tag, ".data"}, o.d, e.d);
      chk({tag, ".frame_error"}, o.fe, e.fe);
      chk({tag, ".parity_error"}, o.pe, e.pe);
      chk({tag, ".break_detect"}, o.brk, e.brk);
      chk({tag, ".oe_cycle"}, o.cyc, e.cyc);
    end
    obs_q.delete();
    exp_q.delete();
  endtask

  initial begin
    int inst, sb;
    logic [8:0] word;
    logic [1:0] stops;

    reset = 1'b1;
    rx_a = 1'b1;
    rx_b = 1'b1;
    rx_c = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset.oe_a", oe_a, 0);
    chk("reset.data_a", data_a, 0);
    chk("reset.flags_a", {fe_a, pe_a, brk_a}, 0);
    chk("reset.oe_b", oe_b, 0);
    chk("reset.flags_b", {fe_b, pe_b, brk_b}, 0);
    chk("reset.oe_c", oe_c, 0);
    chk("reset.data_c", data_c, 0);
    reset = 1'b0;
    repeat (5) @(negedge clk);

    // 8N1 0x55 with exact oe timing.
    send_frame(0, 9'h55, 1'b0, 2'b11, -1, D);
    drive(0, 1'b1, D);
    check_all("t1_55");

    // Even parity: bad parity bit, then correct parity bit.
    send_frame(1, 9'hA3, 1'b1, 2'b11, -1, D);
    drive(1, 1'b1, D);
    check_all("t2_par_bad");
    send_frame(1, 9'hA3, 1'b0, 2'b11, -1, D);
    drive(1, 1'b1, D);
    check_all("t2_par_ok");

    // Low stop bit, line returns high, then a clean frame.
    send_frame(0, 9'h3C, 1'b0, 2'b10, -1, D);
    drive(0, 1'b1, D);
    send_frame(0, 9'h41, 1'b0, 2'b11, -1, D);
    drive(0, 1'b1, D);
    check_all("t3_framing");

    // Line held low: one break delivery, nothing more while low, then a clean frame.
    line_low(0, 20 * D);
    check_all("t4_break");
    drive(0, 1'b1, 2 * D);
    check_all("t4_after_high");
    send_frame(0, 9'h0A, 1'b0, 2'b11, -1, D);
    drive(0, 1'b1, D);
    check_all("t4_0a");

    // Short low pulse is a false start; then a 1-cycle glitch on data bit 2 of 0xFF.
    line_low(0, 10);
    drive(0, 1'b1, 3 * D);
    check_all("t5_false_start");
    send_frame(0, 9'hFF, 1'b0, 2'b11, 3, D);
    drive(0, 1'b1, D);
    check_all("t5_glitch");

    // Reset in the middle of 0x77 data bits.
    wave.delete();
    drive(0, 1'b0, D);
    drive(0, 1'b1, 3 * D);
    drive(0, 1'b0, D / 2);
    reset = 1'b1;
    set_rx(0, 1'b1);
    repeat (4) @(negedge clk);
    chk("t6_reset.oe_a", oe_a, 0);
    chk("t6_reset.data_a", data_a, 0);
    reset = 1'b0;
    drive(0, 1'b1, 2 * D);
    check_all("t6_aborted");
    send_frame(0, 9'h12, 1'b0, 2'b11, -1, D);
    drive(0, 1'b1, D);
    check_all("t6_12");
    send_frame(2, 9'h12, 1'b0, 2'b11, -1, D);
    drive(2, 1'b1, D);
    check_all("t6_12_7n2");

    // Back-to-back: next start edge right after the last stop centre.
    send_frame(0, 9'($urandom), 1'b0, 2'b11, -1, D / 2 + 1);
    send_frame(0, 9'($urandom), 1'b0, 2'b11, -1, D / 2 + 1);
    send_frame(0, 9'($urandom), 1'b0, 2'b11, -1, D);
    check_all("t7_b2b");

    // Random frames across all three builds.
    for (int n = 0; n < 12; n++) begin
      inst  = $urandom_range(0, 2);
      word  = 9'($urandom);
      stops = ($urandom_range(0, 3) == 0) ? 2'($urandom) : 2'b11;
      sb    = cfg_sb(inst);
      send_frame(inst, word, ($urandom_range(0, 3) == 0), stops, -1,
                 ($urandom_range(0, 1) == 0) ? D / 2 + 1 : D);
      if (!stops[sb-1]) drive(inst, 1'b1, D);
    end
    drive(0, 1'b1, D);
    check_all("t8_random");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
